// File: rtl/instr_line_refill_pkg.sv
// Shared constants and types for the L1 instruction-line refill engine.
package instr_line_refill_pkg;

    localparam int WORDS  = 8;              // 32-bit words per cache line
    localparam int IDX_W  = 3;              // log2(WORDS)
    localparam int LINE_W = 32 * WORDS;     // assembled line width
    localparam int TAG_W  = 32 - IDX_W;     // line tag = word address without word index

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One bit wider than the word index so a full line count never wraps.
    typedef logic [IDX_W:0] cnt_t;

endpackage

// File: rtl/instr_line_refill_buf.sv
// Word-indexed line buffer with a flat line-wide read port. A word being
// written this cycle is forwarded to the read port so the line can be taken
// in the same cycle as its final beat.
module refill_line_buf
    import instr_line_refill_pkg::*;
(
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [31:0]       wr_data,
    output logic [LINE_W-1:0] rd_line
);

    logic [31:0] words [WORDS];

    // Store one returned beat per cycle at its word slot.
    // NOTE: the storage has no reset; it is only read after a complete fill has rewritten every word.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Flatten the words into a line, forwarding the word being written.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < WORDS; k++) begin
            rd_line[32*k +: 32] = (wr_en && (wr_idx == IDX_W'(k))) ? wr_data : words[k];
        end
    end

endmodule

// File: rtl/instr_line_refill.sv
// Refill engine below the L1 instruction cache: fetches an 8-word line as
// single-word memory reads, assembles it, and returns it with a one-cycle
// valid pulse. A request for a different line mid-fill drains the
// outstanding reads and abandons the old line.
module instr_line_refill
    import instr_line_refill_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic [31:0]       req_addr,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output logic [31:0]       line_addr,
    output logic              busy,
    output logic              rd_req,
    output logic [31:0]       rd_addr,
    input  logic              rd_gnt,
    input  logic [31:0]       rd_data,
    input  logic              rd_valid
);

    state_t            state, state_nxt;
    logic [TAG_W-1:0]  req_tag, cur_tag, last_tag;
    logic              last_vld;
    cnt_t              issue_cnt, ret_cnt, outstanding;
    logic              start, begin_fill, fill_done, redirect, drain_done;
    logic              buf_wr, ret_adv;
    logic [LINE_W-1:0] buf_line;
    logic [IDX_W-1:0]  unused_addr_bits;

    // The word-index bits of the request address do not select a line.
    assign unused_addr_bits = req_addr[IDX_W-1:0];

    assign req_tag     = req_addr[31:IDX_W];
    // A held request for the line just delivered must not refetch it.
    assign start       = req & ~(last_vld & (req_tag == last_tag));
    assign outstanding = issue_cnt - ret_cnt;
    assign fill_done   = (state == FILL) & rd_valid & (ret_cnt == cnt_t'(WORDS - 1));
    assign redirect    = (state == FILL) & req & (req_tag != cur_tag);
    assign drain_done  = (state == DRAIN) &
                         ((outstanding == '0) | ((outstanding == cnt_t'(1)) & rd_valid));
    assign begin_fill  = (state_nxt == FILL) & (state != FILL);
    assign buf_wr      = (state == FILL) & rd_valid;
    // In DRAIN, beats are only counted while some are still owed.
    assign ret_adv     = rd_valid & ((state == FILL) | ((state == DRAIN) & (outstanding != '0)));

    refill_line_buf u_buf (
        .CLK     (CLK),
        .wr_en   (buf_wr),
        .wr_idx  (ret_cnt[IDX_W-1:0]),
        .wr_data (rd_data),
        .rd_line (buf_line)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fill completion wins over a same-cycle redirect.
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL: begin
                if (fill_done)     state_nxt = IDLE;
                else if (redirect) state_nxt = DRAIN;
            end
            DRAIN:   if (drain_done) state_nxt = start ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request and status outputs decoded from state and issue count.
    always_comb begin
        rd_req  = (state == FILL) & (issue_cnt < cnt_t'(WORDS));
        rd_addr = rd_req ? {cur_tag, issue_cnt[IDX_W-1:0]} : '0;
        busy    = (state != IDLE);
    end

    // Counters, tags and the registered line outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cur_tag    <= '0;
            last_tag   <= '0;
            last_vld   <= 1'b0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            line_valid <= 1'b0;
            line_addr  <= '0;
            line_data  <= '0;
        end else begin
            line_valid <= 1'b0;
            if (begin_fill) begin
                cur_tag   <= req_tag;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (rd_req & rd_gnt) issue_cnt <= issue_cnt + cnt_t'(1);
                if (ret_adv)         ret_cnt   <= ret_cnt + cnt_t'(1);
            end
            if (fill_done) begin
                line_valid <= 1'b1;
                line_addr  <= {cur_tag, {IDX_W{1'b0}}};
                line_data  <= buf_line;
                last_tag   <= cur_tag;
                last_vld   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_line_refill.sv
// Scoreboard bench for instr_line_refill: a randomized in-order memory
// responder, a queue of expected lines built from address arithmetic, and a
// monitor that pops and compares on every line_valid.
module tb_instr_line_refill;
    import instr_line_refill_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              req = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [LINE_W-1:0] line_data;
    logic              line_valid;
    logic [31:0]       line_addr;
    logic              busy;
    logic              rd_req;
    logic [31:0]       rd_addr;
    logic              rd_gnt = 1'b0;
    logic [31:0]       rd_data = '0;
    logic              rd_valid = 1'b0;

    typedef struct { logic [31:0] addr; int ready; } resp_t;
    typedef struct { logic [31:0] addr; logic [LINE_W-1:0] data; } line_t;

    resp_t             resp_q[$];
    line_t             exp_q[$];
    logic [31:0]       issued_q[$];
    logic [LINE_W-1:0] last_data = '0;
    logic [31:0]       salt = '0;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1, last_ready = 0;
    int resp_cnt = 0, rd_req_cycles = 0, lines_seen = 0, line_cyc = 0, fill_t0 = 0;

    instr_line_refill dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req        (req),
        .req_addr   (req_addr),
        .line_data  (line_data),
        .line_valid (line_valid),
        .line_addr  (line_addr),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // Memory shares RESET: anything in flight is lost at a reset edge.
    always @(posedge CLK) begin
        if (RESET) begin
            resp_q.delete();
            last_ready = 0;
        end
    end

    // In-order memory: return due beats, then grant new requests with random latency.
    always @(negedge CLK) begin : mem_model
        resp_t r;
        if (resp_q.size() != 0 && resp_q[0].ready <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = mem_word(resp_q[0].addr);
            resp_q.delete(0);
            resp_cnt++;
            check("valid_only_while_busy", busy, 1'b1);
        end else begin
            rd_valid = 1'b0;
            rd_data  = $urandom;
        end
        if (rd_req) begin
            rd_req_cycles++;
            rd_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
            if (rd_gnt) begin
                r.addr  = rd_addr;
                r.ready = cyc + int'($urandom_range(lat_max, lat_min));
                if (r.ready < last_ready) r.ready = last_ready;
                last_ready = r.ready;
                resp_q.push_back(r);
                issued_q.push_back(rd_addr);
            end
        end else begin
            rd_gnt = 1'($urandom_range(1, 0));
        end
    end

    // Monitor: every returned line must match the oldest expected line.
    always @(negedge CLK) begin : line_monitor
        line_t e;
        if (line_valid) begin
            lines_seen++;
            line_cyc = cyc;
            check("line_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("line_addr", line_addr, e.addr);
                check("line_data", line_data, e.data);
                last_data = e.data;
            end
        end
    end

    task automatic push_exp(input logic [31:0] a);
        line_t e;
        e.addr = a & ~32'(WORDS - 1);
        e.data = '0;
        for (int k = 0; k < WORDS; k++) e.data[32*k +: 32] = mem_word(e.addr + 32'(k));
        exp_q.push_back(e);
    endtask

    task automatic wait_line(input int seen0);
        int n = 0;
        while (lines_seen == seen0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        check("line_arrived", lines_seen > seen0, 1'b1);
        @(negedge CLK);
    endtask

    task automatic wait_returns(input int count);
        int base = resp_cnt;
        int n = 0;
        while (resp_cnt - base < count && n < 100) begin
            @(posedge CLK);
            n++;
        end
        check("returns_arrived", resp_cnt - base >= count, 1'b1);
    endtask

    task automatic do_fill(input logic [31:0] a, input bit drop);
        int seen0;
        @(negedge CLK);
        issued_q.delete();
        req      = 1'b1;
        req_addr = a;
        fill_t0  = cyc;
        seen0    = lines_seen;
        push_exp(a);
        if (drop) begin
            repeat (3) @(negedge CLK);
            req = 1'b0;
        end
        wait_line(seen0);
    endtask

    task automatic check_issues(input logic [31:0] base);
        check("issue_count", issued_q.size(), WORDS);
        for (int k = 0; k < issued_q.size() && k < WORDS; k++)
            check("issue_addr", issued_q[k], base + 32'(k));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] a, prev;
        int rc, ls, seen0;

        // Reset held two cycles with a request pending.
        req = 1'b1;
        req_addr = 32'h40;
        repeat (2) @(negedge CLK);
        check("reset_line_valid", line_valid, 1'b0);
        check("reset_rd_req", rd_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_line_addr", line_addr, 32'h0);
        check("reset_line_data", line_data, '0);
        req = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);

        // Basic fill at minimum latency, data equals address.
        do_fill(32'h40, 1'b0);
        check("min_latency", line_cyc - fill_t0, WORDS + 2);
        check_issues(32'h40);

        // Held request for the delivered line starts nothing; line_data holds.
        rc = rd_req_cycles;
        ls = lines_seen;
        repeat (20) @(posedge CLK);
        check("held_req_no_issue", rd_req_cycles - rc, 0);
        check("held_req_no_line", lines_seen - ls, 0);
        check("line_data_holds", line_data, last_data);
        do_fill(32'h48, 1'b0);
        check_issues(32'h48);

        // Backpressure and variable latency; one fill drops req midway.
        gnt_pct = 50;
        lat_min = 1;
        lat_max = 4;
        prev = 32'h48;
        for (int i = 0; i < 6; i++) begin
            salt = $urandom;
            do a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
            while ((a & ~32'(WORDS - 1)) == prev);
            prev = a & ~32'(WORDS - 1);
            do_fill(a, i == 2);
            check_issues(prev);
        end

        // Redirect after three returns: 0x80 is abandoned, 0x100 delivered.
        gnt_pct = 100;
        lat_min = 2;
        lat_max = 3;
        salt = $urandom;
        @(negedge CLK);
        req = 1'b1;
        req_addr = 32'h80;
        wait_returns(3);
        @(negedge CLK);
        req_addr = 32'h100;
        seen0 = lines_seen;
        push_exp(32'h100);
        @(negedge CLK);
        check("drain_rd_req", rd_req, 1'b0);
        check("drain_busy", busy, 1'b1);
        wait_line(seen0);

        // Reset after four beats: idle next cycle, then the full line is refetched.
        lat_min = 1;
        lat_max = 2;
        @(negedge CLK);
        req_addr = 32'h1C0;
        wait_returns(4);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("midreset_busy", busy, 1'b0);
        check("midreset_rd_req", rd_req, 1'b0);
        check("midreset_line_valid", line_valid, 1'b0);
        issued_q.delete();
        seen0 = lines_seen;
        push_exp(32'h1C0);
        RESET = 1'b0;
        wait_line(seen0);
        check_issues(32'h1C0);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
